// File: rtl/pc_fetch_stage.sv
// ---------------------------------------------------------------------------
// pc_fetch_stage
//
// Pipeline stage 1 (fetch). Owns the PC register and keeps at most one
// instruction fetch outstanding to imem. Each fetched instruction is placed
// in an output register and handed to stage 2 over a valid/allow_in
// handshake. A redirect from a later stage replaces the PC, flushes the
// output register and discards whatever fetch is still in flight.
//
// Ports
//   clk               in   clock, rising edge
//   rst               in   synchronous, active-high reset
//   imem_req_valid    out  fetch request valid
//   imem_req_ready    in   imem accepts the request this cycle
//   imem_req_addr     out  fetch address (current PC)
//   imem_resp_valid   in   fetch response valid (never backpressured)
//   imem_resp_instr   in   fetched instruction
//   imem_resp_err     in   access fault for this response
//   redirect_valid    in   flush and load a new PC
//   redirect_pc       in   redirect target (bits [1:0] are ignored)
//   regD_allow_in     in   stage 2 can accept this cycle
//   pc_to_regD_valid  out  output register holds a valid instruction
//   pc_to_regD_pc     out  PC of the held instruction
//   pc_to_regD_instr  out  held instruction
//   pc_to_regD_fault  out  held instruction faulted on fetch
// ---------------------------------------------------------------------------
module pc_fetch_stage #(
    parameter int                WIDTH      = 64,
    parameter int                INSTR_SIZE = 32,
    parameter logic [WIDTH-1:0]  RESET_PC   = 64'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [WIDTH-1:0]      imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INSTR_SIZE-1:0] imem_resp_instr,
    input  logic                  imem_resp_err,
    input  logic                  redirect_valid,
    input  logic [WIDTH-1:0]      redirect_pc,
    input  logic                  regD_allow_in,
    output logic                  pc_to_regD_valid,
    output logic [WIDTH-1:0]      pc_to_regD_pc,
    output logic [INSTR_SIZE-1:0] pc_to_regD_instr,
    output logic                  pc_to_regD_fault
);

    // REQ : issuing a fetch for pc_q
    // WAIT: fetch accepted, waiting for its response
    // DROP: a stale fetch is outstanding; its response is thrown away
    // HALT: last fetch faulted; idle until redirected
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      pc_q, pc_d;
    logic                  out_valid_q;
    logic [WIDTH-1:0]      out_pc_q;
    logic [INSTR_SIZE-1:0] out_instr_q;
    logic                  out_fault_q;

    logic accept;
    logic handover;
    logic load_out;

    // A request is only issued when the output register is empty or is
    // being emptied this cycle, so a response arriving in WAIT always finds
    // the output register free.
    assign imem_req_valid = !rst && (state_q == S_REQ) && (!out_valid_q || regD_allow_in);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign handover       = out_valid_q && regD_allow_in;

    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        load_out = 1'b0;

        if (redirect_valid) begin
            // Redirect overrides everything else happening this cycle.
            pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
            unique case (state_q)
                S_REQ:          state_d = accept ? S_DROP : S_REQ;
                S_WAIT, S_DROP: state_d = imem_resp_valid ? S_REQ : S_DROP;
                S_HALT:         state_d = S_REQ;
                default:        state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (accept) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        load_out = 1'b1;
                        if (imem_resp_err) begin
                            // Keep pc_q pointing at the faulting address.
                            state_d = S_HALT;
                        end else begin
                            pc_d    = pc_q + WIDTH'(4);
                            state_d = S_REQ;
                        end
                    end
                end
                S_DROP: begin
                    if (imem_resp_valid) state_d = S_REQ;
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // NOTE: the output data fields are reset along with the valid bit so
    // stage 2 sees all-zero fields out of reset, not just a cleared valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            out_fault_q <= 1'b0;
        end else if (redirect_valid) begin
            // Flush; a handover in the same cycle is also flushed downstream.
            out_valid_q <= 1'b0;
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= pc_q;
            out_instr_q <= imem_resp_instr;
            out_fault_q <= imem_resp_err;
        end else if (handover) begin
            out_valid_q <= 1'b0;
        end
    end

    assign pc_to_regD_valid = out_valid_q;
    assign pc_to_regD_pc    = out_pc_q;
    assign pc_to_regD_instr = out_instr_q;
    assign pc_to_regD_fault = out_fault_q;

endmodule
